// File: rtl/snake_pkg.sv
// Shared definitions for the snake move controller: grid defaults,
// position packing, heading encodings and the controller state enum.
package snake_pkg;

  localparam int POS_W = 11;
  localparam int X_W   = 6;
  localparam int Y_W   = 5;

  localparam int DEF_MAX_LEN = 10;
  localparam int DEF_GRID_W  = 40;
  localparam int DEF_GRID_H  = 30;
  localparam int DEF_START_X = 20;
  localparam int DEF_START_Y = 15;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  // A body segment, packed {y, x} to match the renderer bus layout
  typedef struct packed {
    logic [Y_W-1:0] y;
    logic [X_W-1:0] x;
  } pos_t;

  typedef enum logic [2:0] {
    IDLE,
    MOVE,
    CHECK,
    EAT,
    OVER
  } state_t;

endpackage

// File: rtl/snake_step_controller_if.sv
// Bundle of the move-request, apple handshake and body-bus signals around
// the snake step controller. The controller uses the slave view.
interface snake_step_controller_if
  import snake_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN
);

  logic                       tick;
  logic [1:0]                 direction;
  logic [X_W-1:0]             apple_x;
  logic [Y_W-1:0]             apple_y;
  logic                       apple_ack;
  logic                       apple_req;
  logic [POS_W*MAX_LEN-1:0]   snake_flat;
  logic [3:0]                 length;
  logic [7:0]                 score;
  logic                       busy;
  logic                       game_over;

  modport master (
    output tick, direction, apple_x, apple_y, apple_ack,
    input  apple_req, snake_flat, length, score, busy, game_over
  );

  modport slave (
    input  tick, direction, apple_x, apple_y, apple_ack,
    output apple_req, snake_flat, length, score, busy, game_over
  );

endinterface

// File: rtl/snake_next_head.sv
// Next head position for a given heading, plus wall detection.
// Optional macro SNAKE_WRAP_EN: the playfield becomes a torus and no wall
// hit is ever reported.
module snake_next_head
  import snake_pkg::*;
#(
  parameter int GRID_W = DEF_GRID_W,
  parameter int GRID_H = DEF_GRID_H
) (
  input  pos_t       head,
  input  logic [1:0] dir,
  output pos_t       next_head,
  output logic       wall_hit
);

  logic [X_W-1:0] step_x;
  logic [Y_W-1:0] step_y;

  // One step in the chosen heading with unsigned wrap, then wall/wrap handling
  always_comb begin
    step_x = head.x;
    step_y = head.y;
    case (dir)
      DIR_UP:    step_y = head.y - Y_W'(1);
      DIR_RIGHT: step_x = head.x + X_W'(1);
      DIR_DOWN:  step_y = head.y + Y_W'(1);
      default:   step_x = head.x - X_W'(1);
    endcase
`ifdef SNAKE_WRAP_EN
    wall_hit    = 1'b0;
    next_head.x = step_x;
    next_head.y = step_y;
    if (step_x == X_W'(GRID_W))
      next_head.x = '0;
    else if (step_x == '1)
      next_head.x = X_W'(GRID_W - 1);
    if (step_y == Y_W'(GRID_H))
      next_head.y = '0;
    else if (step_y == '1)
      next_head.y = Y_W'(GRID_H - 1);
`else
    next_head.x = step_x;
    next_head.y = step_y;
    wall_hit    = (step_x >= X_W'(GRID_W)) || (step_y >= Y_W'(GRID_H));
`endif
  end

endmodule

// File: rtl/snake_step_controller.sv
// Snake step controller: one move per IDLE tick, owns the body register
// file, scans for self collision one segment per cycle and runs the apple
// request/acknowledge handshake. Optional macro SNAKE_WRAP_EN (wrapping
// playfield, handled inside snake_next_head).
module snake_step_controller
  import snake_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int GRID_W  = DEF_GRID_W,
  parameter int GRID_H  = DEF_GRID_H,
  parameter int START_X = DEF_START_X,
  parameter int START_Y = DEF_START_Y
) (
  input logic                     clk,
  input logic                     reset,
  snake_step_controller_if.slave  bus
);

  localparam logic [3:0] MAX_LEN_L = 4'(MAX_LEN);

  state_t     state;
  pos_t       seg [MAX_LEN];
  logic [1:0] last_dir;
  logic [3:0] idx;
  logic [3:0] length_q;
  logic [7:0] score_q;
  logic       apple_req_q;
  logic       game_over_q;

  logic       reverse;
  logic [1:0] eff_dir;
  pos_t       next_head;
  logic       wall_hit;
  logic       scan_hit;
  logic       apple_hit;

  // A 180-degree turn would run the head into its own neck, so ignore it
  always_comb begin
    reverse = (length_q > 4'd1) && ((bus.direction ^ last_dir) == 2'b10);
    eff_dir = reverse ? last_dir : bus.direction;
  end

  snake_next_head #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H)
  ) u_next_head (
    .head      (seg[0]),
    .dir       (eff_dir),
    .next_head (next_head),
    .wall_hit  (wall_hit)
  );

  // Compare the segment under the scan index against the head
  always_comb begin
    scan_hit = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      if ((idx == 4'(i)) && (seg[i] == seg[0]))
        scan_hit = 1'b1;
    end
    apple_hit = (seg[0] == {bus.apple_y, bus.apple_x});
  end

  // Move sequencer: IDLE -> MOVE -> CHECK scan -> (EAT handshake) -> IDLE, or OVER
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      seg[0]      <= {Y_W'(START_Y), X_W'(START_X)};
      for (int i = 1; i < MAX_LEN; i++)
        seg[i] <= '0;
      length_q    <= 4'd1;
      score_q     <= 8'd0;
      apple_req_q <= 1'b0;
      game_over_q <= 1'b0;
      last_dir    <= DIR_RIGHT;
      idx         <= 4'd1;
    end else begin
      case (state)
        IDLE: begin
          if (bus.tick)
            state <= MOVE;
        end
        MOVE: begin
          if (!reverse)
            last_dir <= bus.direction;
          if (wall_hit) begin
            state       <= OVER;
            game_over_q <= 1'b1;
          end else begin
            for (int i = MAX_LEN - 1; i > 0; i--)
              seg[i] <= seg[i-1];
            seg[0] <= next_head;
            idx    <= 4'd1;
            state  <= CHECK;
          end
        end
        CHECK: begin
          if (idx >= length_q) begin
            if (apple_hit) begin
              state       <= EAT;
              apple_req_q <= 1'b1;
              if (length_q < MAX_LEN_L)
                length_q <= length_q + 4'd1;
            end else begin
              state <= IDLE;
            end
          end else if (scan_hit) begin
            state       <= OVER;
            game_over_q <= 1'b1;
          end else begin
            idx <= idx + 4'd1;
          end
        end
        EAT: begin
          if (bus.apple_ack) begin
            apple_req_q <= 1'b0;
            if (score_q != 8'hFF)
              score_q <= score_q + 8'd1;
            state <= IDLE;
          end
        end
        OVER: begin
          state <= OVER;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < MAX_LEN; g++) begin : g_flat
    assign bus.snake_flat[POS_W*g +: POS_W] = seg[g];
  end

  assign bus.length    = length_q;
  assign bus.score     = score_q;
  assign bus.apple_req = apple_req_q;
  assign bus.game_over = game_over_q;
  assign bus.busy      = (state != IDLE);

endmodule
